// File: rtl/ttn_pll_pkg.sv
// Shared types and default parameter values for the PLL lock-detect slice.
package ttn_pll_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ERR_W       = 16;
  localparam int DEF_LOCK_CNT    = 8;
  localparam int DEF_UNLOCK_CNT  = 2;

  // Phase-measurement FSM: waiting for nothing, or for the partner of a seen edge.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_FB  = 2'd1,
    WAIT_REF = 2'd2
  } lock_state_t;

endpackage

// File: rtl/ttn_edge_sync.sv
// Synchronizer chain plus history flop for one asynchronous clock-like input.
// Emits a single-cycle rise pulse; arming after reset is handled by the parent.
module ttn_edge_sync
  import ttn_pll_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;

  // Shift the raw input through the chain; remember the last synced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/ttn_lock_detect.sv
// Sampled lock detector: measures ref/fb rising-edge phase error in clk cycles
// and tracks lock with run-length counters of good/bad evaluations.
module ttn_lock_detect
  import ttn_pll_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ERR_W       = DEF_ERR_W,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT  = DEF_UNLOCK_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refclk,
  input  logic             fbclk,
  input  logic [ERR_W-1:0] tolerance,
  output logic [ERR_W-1:0] phase_err,
  output logic             lead,
  output logic             err_valid,
  output logic             locked
);

  localparam int ARM_W  = $clog2(SYNC_STAGES + 2);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  UNLOCK_V = BAD_W'(UNLOCK_CNT);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  logic              ref_rise, fb_rise, ref_edge, fb_edge, armed;
  logic [ARM_W-1:0]  arm_reg;
  lock_state_t       state_reg, state_next;
  logic [ERR_W-1:0]  cnt_reg, cnt_next, cnt_plus1;
  logic              eval_fire, eval_lead, eval_good;
  logic [ERR_W-1:0]  eval_err;
  logic [GOOD_W-1:0] good_cnt_reg, good_inc;
  logic [BAD_W-1:0]  bad_cnt_reg, bad_inc;
  logic [ERR_W-1:0]  phase_err_reg;
  logic              lead_reg, err_valid_reg, locked_reg;

  ttn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk(clk), .reset(reset), .din(refclk), .rise(ref_rise)
  );
  ttn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk(clk), .reset(reset), .din(fbclk), .rise(fb_rise)
  );

  // Hold off edge detection until the synchronizers have flushed reset-time levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 arm_reg <= '0;
    else if (arm_reg != ARM_DONE) arm_reg <= arm_reg + 1'b1;
  end

  assign armed    = (arm_reg == ARM_DONE);
  assign ref_edge = ref_rise & armed;
  assign fb_edge  = fb_rise & armed;
  assign cnt_plus1 = (cnt_reg == ERR_MAX) ? ERR_MAX : cnt_reg + 1'b1;

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: a same-type edge in a wait state always restarts the wait,
  // whether or not the partner edge arrived in the same cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (ref_edge && !fb_edge) begin
          state_next = WAIT_FB;
          cnt_next   = '0;
        end else if (fb_edge && !ref_edge) begin
          state_next = WAIT_REF;
          cnt_next   = '0;
        end
      end
      WAIT_FB: begin
        if (ref_edge)                cnt_next   = '0;
        else if (fb_edge)            state_next = IDLE;
        else if (cnt_reg == ERR_MAX) state_next = IDLE;
        else                         cnt_next   = cnt_reg + 1'b1;
      end
      WAIT_REF: begin
        if (fb_edge)                 cnt_next   = '0;
        else if (ref_edge)           state_next = IDLE;
        else if (cnt_reg == ERR_MAX) state_next = IDLE;
        else                         cnt_next   = cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Evaluation decode: partner arrival measures, missing partner or timeout is all-ones.
  always_comb begin
    eval_fire = 1'b0;
    eval_err  = '0;
    eval_lead = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ref_edge && fb_edge) eval_fire = 1'b1;
      end
      WAIT_FB: begin
        eval_lead = 1'b1;
        if (fb_edge) begin
          eval_fire = 1'b1;
          eval_err  = cnt_plus1;
        end else if (ref_edge || cnt_reg == ERR_MAX) begin
          eval_fire = 1'b1;
          eval_err  = ERR_MAX;
        end
      end
      WAIT_REF: begin
        if (ref_edge) begin
          eval_fire = 1'b1;
          eval_err  = cnt_plus1;
        end else if (fb_edge || cnt_reg == ERR_MAX) begin
          eval_fire = 1'b1;
          eval_err  = ERR_MAX;
        end
      end
      default: eval_fire = 1'b0;
    endcase
  end

  assign eval_good = (eval_err <= tolerance);
  assign good_inc  = good_cnt_reg + 1'b1;
  assign bad_inc   = bad_cnt_reg + 1'b1;

  // Registered measurement outputs; phase_err/lead hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid_reg <= 1'b0;
      phase_err_reg <= '0;
      lead_reg      <= 1'b0;
    end else begin
      err_valid_reg <= eval_fire;
      if (eval_fire) begin
        phase_err_reg <= eval_err;
        lead_reg      <= eval_lead;
      end
    end
  end

  // Lock hysteresis: consecutive-good run to lock, consecutive-bad run to unlock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_reg   <= 1'b0;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else if (eval_fire) begin
      if (!locked_reg) begin
        if (eval_good) begin
          good_cnt_reg <= good_inc;
          if (good_inc == LOCK_V) begin
            locked_reg  <= 1'b1;
            bad_cnt_reg <= '0;
          end
        end else begin
          good_cnt_reg <= '0;
        end
      end else begin
        if (!eval_good) begin
          if (bad_inc == UNLOCK_V) begin
            locked_reg   <= 1'b0;
            good_cnt_reg <= '0;
            bad_cnt_reg  <= '0;
          end else begin
            bad_cnt_reg <= bad_inc;
          end
        end else begin
          bad_cnt_reg <= '0;
        end
      end
    end
  end

  assign phase_err = phase_err_reg;
  assign lead      = lead_reg;
  assign err_valid = err_valid_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_ttn_lock_detect.sv
// Self-checking bench for ttn_lock_detect: table-driven periodic vectors,
// hand-written reset/lock-loss sequences, and randomized edges vs a model.
module tb_ttn_lock_detect;

  localparam logic [15:0] ALL1 = 16'hFFFF;
  localparam int LOCK_N = 8;
  localparam int UNLOCK_N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        refclk = 1'b0;
  logic        fbclk = 1'b0;
  logic [15:0] tolerance = 16'd0;
  logic [15:0] phase_err;
  logic        lead, err_valid, locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] err;
    logic        lead;
    logic        chk_lead;
    logic        locked;
  } ev_t;

  typedef struct {
    int          lag;
    logic [15:0] tol;
    int          n;
    logic [15:0] exp_err;
    logic        exp_lead;
    logic        exp_good;
  } vec_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  vec_t vecs[7];

  // reference-model state (edge-event level)
  int m_pend, m_ts, m_n, m_good_run, m_bad_run;
  bit m_locked;

  ttn_lock_detect dut (
    .clk(clk), .reset(reset), .refclk(refclk), .fbclk(fbclk),
    .tolerance(tolerance), .phase_err(phase_err), .lead(lead),
    .err_valid(err_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_valid) obs_q.push_back('{phase_err, lead, 1'b1, locked});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic ref_lvl);
    @(negedge clk);
    reset = 1'b1;
    refclk = ref_lvl;
    fbclk = 1'b0;
    tick(3);
    reset = 1'b0;
    obs_q.delete();
    tick(6);
  endtask

  task automatic drive_periods(input int lag, input int n, input bit fb_en);
    int roff, foff;
    roff = (lag < 0) ? -lag : 0;
    foff = (lag > 0) ? lag : 0;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 20; c++) begin
        refclk = (c >= roff && c < roff + 10);
        fbclk  = fb_en && (c >= foff && c < foff + 10);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_pulses(input string name, input int n, input logic [15:0] err,
                              input logic ld, input bit good);
    check($sformatf("%s count", name), obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      check($sformatf("%s[%0d] err", name, i), obs_q[i].err, err);
      check($sformatf("%s[%0d] lead", name, i), obs_q[i].lead, ld);
      check($sformatf("%s[%0d] locked", name, i), obs_q[i].locked, good && (i >= LOCK_N - 1));
    end
  endtask

  task automatic model_eval(input logic [15:0] err, input logic ld, input bit chk);
    bit good;
    good = (err <= tolerance);
    if (!m_locked) begin
      if (good) begin
        m_good_run++;
        if (m_good_run >= LOCK_N) begin
          m_locked = 1'b1;
          m_bad_run = 0;
        end
      end else m_good_run = 0;
    end else begin
      if (!good) begin
        m_bad_run++;
        if (m_bad_run >= UNLOCK_N) begin
          m_locked = 1'b0;
          m_good_run = 0;
          m_bad_run = 0;
        end
      end else m_bad_run = 0;
    end
    exp_q.push_back('{err, ld, chk, m_locked});
  endtask

  // One drive cycle of the model: r/f are rising edges seen at the pins.
  task automatic model_step(input bit r, input bit f);
    case (m_pend)
      0: begin
        if (r && f) model_eval(16'd0, 1'b0, 1'b1);
        else if (r) begin m_pend = 1; m_ts = m_n; end
        else if (f) begin m_pend = 2; m_ts = m_n; end
      end
      1: begin
        if (f) begin
          model_eval(16'(m_n - m_ts), 1'b1, 1'b1);
          if (r) m_ts = m_n; else m_pend = 0;
        end else if (r) begin
          model_eval(ALL1, 1'b1, 1'b0);
          m_ts = m_n;
        end
      end
      default: begin
        if (r) begin
          model_eval(16'(m_n - m_ts), 1'b0, 1'b1);
          if (f) m_ts = m_n; else m_pend = 0;
        end else if (f) begin
          model_eval(ALL1, 1'b0, 1'b0);
          m_ts = m_n;
        end
      end
    endcase
    m_n++;
  endtask

  initial begin
    logic [7:0] hist;
    logic base, b, nr, nf;
    int d, dir, nmin;
    int exp_l[12];

    // reset state
    tick(2);
    check("reset phase_err", phase_err, 0);
    check("reset lead", lead, 0);
    check("reset err_valid", err_valid, 0);
    check("reset locked", locked, 0);

    // table: {lag, tolerance, periods, exp err, exp lead, good?}
    vecs[0] = '{ 0, 16'd1, 8, 16'd0, 1'b0, 1'b1};
    vecs[1] = '{ 3, 16'd2, 10, 16'd3, 1'b1, 1'b0};
    vecs[2] = '{ 3, 16'd3, 8, 16'd3, 1'b1, 1'b1};
    vecs[3] = '{-4, 16'd4, 9, 16'd4, 1'b0, 1'b1};
    vecs[4] = '{-4, 16'd3, 8, 16'd4, 1'b0, 1'b0};
    vecs[5] = '{ 5, 16'd5, 8, 16'd5, 1'b1, 1'b1};
    vecs[6] = '{-1, 16'd0, 8, 16'd1, 1'b0, 1'b0};
    for (int v = 0; v < 7; v++) begin
      do_reset(1'b0);
      tolerance = vecs[v].tol;
      drive_periods(vecs[v].lag, vecs[v].n, 1'b1);
      tick(10);
      check_pulses($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_err,
                   vecs[v].exp_lead, vecs[v].exp_good);
      $display("vec%0d lag=%0d tol=%0d pulses=%0d locked=%0d", v, vecs[v].lag,
               vecs[v].tol, obs_q.size(), locked);
    end

    // lock loss: 8 good, 1 bad (hold), 1 good, 2 bad (drop on second)
    do_reset(1'b0);
    tolerance = 16'd1;
    drive_periods(0, 8, 1'b1);
    drive_periods(3, 1, 1'b1);
    drive_periods(0, 1, 1'b1);
    drive_periods(3, 2, 1'b1);
    tick(10);
    exp_l = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    check("lockloss count", obs_q.size(), 12);
    for (int i = 0; i < 12 && i < obs_q.size(); i++)
      check($sformatf("lockloss[%0d] locked", i), obs_q[i].locked, exp_l[i]);
    if (obs_q.size() > 8) check("lockloss bad err", obs_q[8].err, 3);
    $display("lockloss pulses=%0d locked=%0d", obs_q.size(), locked);

    // missing feedback: ref only after lock
    do_reset(1'b0);
    tolerance = 16'd1;
    drive_periods(0, 8, 1'b1);
    drive_periods(0, 4, 1'b0);
    tick(10);
    check("nofb count", obs_q.size(), 11);
    for (int i = 8; i < 11 && i < obs_q.size(); i++) begin
      check($sformatf("nofb[%0d] err", i), obs_q[i].err, ALL1);
      check($sformatf("nofb[%0d] locked", i), obs_q[i].locked, (i == 8) ? 1 : 0);
    end
    $display("nofb pulses=%0d locked=%0d", obs_q.size(), locked);

    // reset during WAIT_FB while locked
    do_reset(1'b0);
    tolerance = 16'd3;
    drive_periods(3, 8, 1'b1);
    check("prereset locked", locked, 1);
    check("prereset phase_err", phase_err, 3);
    refclk = 1'b1;
    tick(8);
    #2 reset = 1'b1;
    #1;
    check("midreset locked", locked, 0);
    check("midreset phase_err", phase_err, 0);
    check("midreset lead", lead, 0);
    check("midreset err_valid", err_valid, 0);
    refclk = 1'b0;
    tick(3);
    reset = 1'b0;
    obs_q.delete();
    tick(10);
    fbclk = 1'b1;
    tick(3);
    refclk = 1'b1;
    tick(15);
    refclk = 1'b0;
    fbclk = 1'b0;
    tick(5);
    check_pulses("postreset", 1, 16'd3, 1'b0, 1'b0);
    $display("postreset pulses=%0d", obs_q.size());

    // refclk held high through reset: no false edge
    do_reset(1'b1);
    tolerance = 16'd1;
    tick(4);
    fbclk = 1'b1;
    tick(5);
    refclk = 1'b0;
    tick(5);
    refclk = 1'b1;
    tick(15);
    refclk = 1'b0;
    fbclk = 1'b0;
    tick(5);
    check_pulses("refhigh", 1, 16'd10, 1'b0, 1'b0);
    $display("refhigh pulses=%0d", obs_q.size());

    // randomized edges vs event-level model
    do_reset(1'b0);
    m_pend = 0; m_ts = 0; m_n = 0; m_good_run = 0; m_bad_run = 0; m_locked = 1'b0;
    exp_q.delete();
    hist = 8'd0;
    base = 1'b0;
    for (int blk = 0; blk < 5; blk++) begin
      tolerance = 16'($urandom_range(0, 6));
      d = $urandom_range(0, 4);
      dir = $urandom_range(0, 1);
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 7) == 0) base = ~base;
        hist = {hist[6:0], base};
        b = hist[d];
        if ($urandom_range(0, 59) == 0) b = ~b;
        nr = (dir != 0) ? b : base;
        nf = (dir != 0) ? base : b;
        model_step(nr & ~refclk, nf & ~fbclk);
        refclk = nr;
        fbclk = nf;
        @(negedge clk);
      end
      repeat (10) begin
        model_step(1'b0, 1'b0);
        @(negedge clk);
      end
    end
    tick(10);
    check("rand count", obs_q.size(), exp_q.size());
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check($sformatf("rand[%0d] err", i), obs_q[i].err, exp_q[i].err);
      if (exp_q[i].chk_lead) check($sformatf("rand[%0d] lead", i), obs_q[i].lead, exp_q[i].lead);
      check($sformatf("rand[%0d] locked", i), obs_q[i].locked, exp_q[i].locked);
    end
    $display("random evaluations=%0d observed=%0d", exp_q.size(), obs_q.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
